popcount_engine: RTL and testbench

POPCOUNT_ENGINE -- requirements
Module: popcount_engine

---
 rtl/popcount_pkg.sv | 37 +++
 rtl/popcount_engine_if.sv | 34 +++
 rtl/popcount_stage.sv | 16 +
 rtl/popcount_engine.sv | 153 +++++++++++++++
 tb/tb_popcount_engine.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/popcount_pkg.sv
// Shared types and elaboration helpers for the popcount engine.
package popcount_pkg;

  // Widest input word the mask helper can describe.
  localparam int MAX_WIDTH = 256;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REDUCE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < value) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // Hamming-weight mask for stage k (0x55.., 0x33.., 0x0F.., ...):
  // bit i is set when it sits in the lower half of its 2^(k+1)-bit field.
  function automatic logic [MAX_WIDTH-1:0] mask(input int k, input int width);
    logic [MAX_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width && ((i >> k) & 1) == 0) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/popcount_engine_if.sv
// Handshake bundle for the popcount engine.
//
// Both handshakes use plain valid/ready: a transfer happens on a rising clock
// edge where valid and ready are both 1. The producer holds valid and its
// payload steady until that edge; ready may change freely.
interface popcount_engine_if
  import popcount_pkg::*;
#(
  parameter int P_WIDTH     = 128,
  parameter int P_ACC_WIDTH = 32
);
  localparam int CW = clog2(P_WIDTH) + 1;

  logic                   i_valid;
  logic                   o_ready;
  logic [P_WIDTH-1:0]     i_data;
  logic                   i_accumulate;
  logic                   i_clear;
  logic                   o_valid;
  logic                   i_ready;
  logic [CW-1:0]          o_count;
  logic [P_ACC_WIDTH-1:0] o_acc;
  logic                   o_acc_sat;

  modport master (
    output i_valid, i_data, i_accumulate, i_clear, i_ready,
    input  o_ready, o_valid, o_count, o_acc, o_acc_sat
  );

  modport slave (
    input  i_valid, i_data, i_accumulate, i_clear, i_ready,
    output o_ready, o_valid, o_count, o_acc, o_acc_sat
  );
endinterface

// File: rtl/popcount_stage.sv
// One mask-shift-add reduction stage: adjacent SHIFT-bit fields are summed
// into 2*SHIFT-bit fields.
module popcount_stage
  import popcount_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int SHIFT = 1
) (
  input  logic [WIDTH-1:0] i_work,
  output logic [WIDTH-1:0] o_work
);
  localparam logic [WIDTH-1:0] M = WIDTH'(mask(clog2(SHIFT), WIDTH));

  // Field sums never overflow their destination field, so no carries leak.
  assign o_work = (i_work & M) + ((i_work >> SHIFT) & M);
endmodule

// File: rtl/popcount_engine.sv
// Multi-cycle popcount with a saturating running accumulator.
// A word is captured in IDLE, reduced over log2(P_WIDTH) stages in REDUCE
// (P_STAGES_PER_CYCLE stages per clock), then presented in HOLD until taken.
module popcount_engine
  import popcount_pkg::*;
#(
  parameter int P_WIDTH            = 128,
  parameter int P_STAGES_PER_CYCLE = 1,
  parameter int P_ACC_WIDTH        = 32
) (
  input  logic   i_clk,
  input  logic   i_reset_n,
  popcount_engine_if.slave bus,
  output state_t o_dbg_state
);
  localparam int N  = clog2(P_WIDTH);
  localparam int CW = N + 1;
  localparam int IW = CW;

  state_t                 state_q;
  logic [P_WIDTH-1:0]     work_q;
  logic [IW-1:0]          idx_q;
  logic                   acc_flag_q;
  logic                   ready_q;
  logic                   valid_q;
  logic [CW-1:0]          count_q;
  logic [P_ACC_WIDTH-1:0] acc_q;
  logic                   sat_q;

  logic [P_WIDTH-1:0]     s0_out [N];
  logic [P_WIDTH-1:0]     slot0;
  logic [P_WIDTH-1:0]     next_work;
  logic                   last_cycle;
  logic [P_ACC_WIDTH:0]   acc_sum;

  // First slot: every stage is built from the working register and the
  // current stage index picks which one is applied this cycle.
  for (genvar k = 0; k < N; k++) begin : g_s0
    popcount_stage #(.WIDTH(P_WIDTH), .SHIFT(1 << k)) u_stage (
      .i_work(work_q),
      .o_work(s0_out[k])
    );
  end

  // Select the slot-0 stage matching the stage index.
  always_comb begin
    slot0 = work_q;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IW'(k)) slot0 = s0_out[k];
    end
  end

  if (P_STAGES_PER_CYCLE == 2) begin : g_two
    logic [P_WIDTH-1:0] s1_out [1:N-1];

    for (genvar k = 1; k < N; k++) begin : g_s1
      popcount_stage #(.WIDTH(P_WIDTH), .SHIFT(1 << k)) u_stage (
        .i_work(slot0),
        .o_work(s1_out[k])
      );
    end

    // Second slot applies stage idx+1; with an odd stage count the final
    // cycle finds no match and passes slot 0 through unchanged.
    always_comb begin
      next_work = slot0;
      for (int k = 1; k < N; k++) begin
        if (idx_q == IW'(k - 1)) next_work = s1_out[k];
      end
    end
  end else begin : g_one
    assign next_work = slot0;
  end

  assign last_cycle = (idx_q >= IW'(N - P_STAGES_PER_CYCLE));

  // Widened sum so an overflow past the accumulator range is visible.
  always_comb begin
    acc_sum = {1'b0, acc_q} + (P_ACC_WIDTH + 1)'(count_q);
  end

  // Control FSM, datapath registers and accumulator; clear overrides any
  // accumulator update made on the same edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      work_q     <= '0;
      idx_q      <= '0;
      acc_flag_q <= 1'b0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      count_q    <= '0;
      acc_q      <= '0;
      sat_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.i_valid) begin
            work_q     <= bus.i_data;
            acc_flag_q <= bus.i_accumulate;
            idx_q      <= '0;
            ready_q    <= 1'b0;
            state_q    <= ST_REDUCE;
          end
        end
        ST_REDUCE: begin
          work_q <= next_work;
          idx_q  <= idx_q + IW'(P_STAGES_PER_CYCLE);
          if (last_cycle) begin
            valid_q <= 1'b1;
            count_q <= next_work[CW-1:0];
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.i_ready) begin
            valid_q <= 1'b0;
            count_q <= '0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
            if (acc_flag_q) begin
              if (acc_sum[P_ACC_WIDTH]) begin
                acc_q <= '1;
                sat_q <= 1'b1;
              end else begin
                acc_q <= acc_sum[P_ACC_WIDTH-1:0];
              end
            end else begin
              acc_q <= P_ACC_WIDTH'(count_q);
            end
          end
        end
        default: begin
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          count_q <= '0;
          state_q <= ST_IDLE;
        end
      endcase
      if (bus.i_clear) begin
        acc_q <= '0;
        sat_q <= 1'b0;
      end
    end
  end

  assign bus.o_ready   = ready_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_count   = count_q;
  assign bus.o_acc     = acc_q;
  assign bus.o_acc_sat = sat_q;
  assign o_dbg_state   = state_q;
endmodule

// File: tb/tb_popcount_engine.sv
// Bench for popcount_engine: four instances driven in lockstep
// (W128/S1/A32, W128/S2/A32, W128/S1/A8, W8/S2/A32) against a bit-counting
// reference with an integer saturating accumulator.
module tb_popcount_engine;
  import popcount_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         i_valid;
  logic         i_accumulate;
  logic         i_clear;
  logic         i_ready;
  logic [127:0] i_data;

  popcount_engine_if #(.P_WIDTH(128), .P_ACC_WIDTH(32)) if_a ();
  popcount_engine_if #(.P_WIDTH(128), .P_ACC_WIDTH(32)) if_b ();
  popcount_engine_if #(.P_WIDTH(128), .P_ACC_WIDTH(8))  if_c ();
  popcount_engine_if #(.P_WIDTH(8),   .P_ACC_WIDTH(32)) if_d ();

  assign if_a.i_valid = i_valid;  assign if_a.i_accumulate = i_accumulate;
  assign if_a.i_clear = i_clear;  assign if_a.i_ready = i_ready;
  assign if_a.i_data  = i_data;
  assign if_b.i_valid = i_valid;  assign if_b.i_accumulate = i_accumulate;
  assign if_b.i_clear = i_clear;  assign if_b.i_ready = i_ready;
  assign if_b.i_data  = i_data;
  assign if_c.i_valid = i_valid;  assign if_c.i_accumulate = i_accumulate;
  assign if_c.i_clear = i_clear;  assign if_c.i_ready = i_ready;
  assign if_c.i_data  = i_data;
  assign if_d.i_valid = i_valid;  assign if_d.i_accumulate = i_accumulate;
  assign if_d.i_clear = i_clear;  assign if_d.i_ready = i_ready;
  assign if_d.i_data  = i_data[7:0];

  state_t st_a, st_b, st_c, st_d;

  popcount_engine #(.P_WIDTH(128), .P_STAGES_PER_CYCLE(1), .P_ACC_WIDTH(32)) u_a (
    .i_clk(clk), .i_reset_n(rst_n), .bus(if_a), .o_dbg_state(st_a));
  popcount_engine #(.P_WIDTH(128), .P_STAGES_PER_CYCLE(2), .P_ACC_WIDTH(32)) u_b (
    .i_clk(clk), .i_reset_n(rst_n), .bus(if_b), .o_dbg_state(st_b));
  popcount_engine #(.P_WIDTH(128), .P_STAGES_PER_CYCLE(1), .P_ACC_WIDTH(8)) u_c (
    .i_clk(clk), .i_reset_n(rst_n), .bus(if_c), .o_dbg_state(st_c));
  popcount_engine #(.P_WIDTH(8), .P_STAGES_PER_CYCLE(2), .P_ACC_WIDTH(32)) u_d (
    .i_clk(clk), .i_reset_n(rst_n), .bus(if_d), .o_dbg_state(st_d));

  // Uniform views of the four instances.
  logic        ov   [4];
  logic        ordy [4];
  logic        osat [4];
  logic [8:0]  ocnt [4];
  logic [31:0] oacc [4];
  state_t      ost  [4];

  assign ov[0] = if_a.o_valid;  assign ordy[0] = if_a.o_ready;  assign osat[0] = if_a.o_acc_sat;
  assign ov[1] = if_b.o_valid;  assign ordy[1] = if_b.o_ready;  assign osat[1] = if_b.o_acc_sat;
  assign ov[2] = if_c.o_valid;  assign ordy[2] = if_c.o_ready;  assign osat[2] = if_c.o_acc_sat;
  assign ov[3] = if_d.o_valid;  assign ordy[3] = if_d.o_ready;  assign osat[3] = if_d.o_acc_sat;
  assign ocnt[0] = 9'(if_a.o_count);  assign oacc[0] = if_a.o_acc;
  assign ocnt[1] = 9'(if_b.o_count);  assign oacc[1] = if_b.o_acc;
  assign ocnt[2] = 9'(if_c.o_count);  assign oacc[2] = 32'(if_c.o_acc);
  assign ocnt[3] = 9'(if_d.o_count);  assign oacc[3] = if_d.o_acc;
  assign ost[0] = st_a;  assign ost[1] = st_b;  assign ost[2] = st_c;  assign ost[3] = st_d;

  // ---------------- reference model ----------------
  int     lat_exp [4] = '{7, 4, 7, 2};
  int     width_of[4] = '{128, 128, 128, 8};
  longint acc_max [4] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFF, 64'hFFFF_FFFF};
  longint exp_acc [4];
  bit     exp_sat [4];

  logic [8:0] exp_q[$];

  function automatic int ref_popcount(input logic [127:0] d, input int width);
    int n;
    n = 0;
    for (int i = 0; i < width; i++) n += int'(d[i]);
    return n;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 4; d++) begin
      exp_acc[d] = 0;
      exp_sat[d] = 1'b0;
    end
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_word(input logic [127:0] data, input logic acc, input int hold,
                          input bit keep_valid, input bit clr_at_hs);
    int         lat [4];
    int         cyc;
    bit         all_up;
    logic [8:0] cnt_exp [4];
    for (int d = 0; d < 4; d++) begin
      check_eq($sformatf("ready_idle[%0d]", d), ordy[d], 1);
      exp_q.push_back(9'(ref_popcount(data, width_of[d])));
      lat[d] = 0;
    end
    i_data       = data;
    i_accumulate = acc;
    i_valid      = 1'b1;
    i_ready      = 1'b0;
    tick();
    if (keep_valid) begin
      i_data       = ~data;
      i_accumulate = ~acc;
    end else begin
      i_valid = 1'b0;
      i_data  = {$urandom, $urandom, $urandom, $urandom};
    end
    cyc    = 0;
    all_up = 1'b0;
    while (!all_up && cyc < 20) begin
      tick();
      cyc++;
      all_up = 1'b1;
      for (int d = 0; d < 4; d++) begin
        if (ov[d] && lat[d] == 0) lat[d] = cyc;
        if (!ov[d]) begin
          all_up = 1'b0;
          check_eq($sformatf("count_zero_busy[%0d]", d), ocnt[d], 0);
        end
        if (lat[d] == 0) check_eq($sformatf("ready_busy[%0d]", d), ordy[d], 0);
      end
    end
    for (int d = 0; d < 4; d++) begin
      check_eq($sformatf("latency[%0d]", d), lat[d], lat_exp[d]);
      cnt_exp[d] = exp_q.pop_front();
      check_eq($sformatf("count[%0d]", d), ocnt[d], cnt_exp[d]);
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      for (int d = 0; d < 4; d++) begin
        check_eq($sformatf("hold_valid[%0d]", d), ov[d], 1);
        check_eq($sformatf("hold_count[%0d]", d), ocnt[d], cnt_exp[d]);
        check_eq($sformatf("hold_ready[%0d]", d), ordy[d], 0);
      end
    end
    i_ready = 1'b1;
    i_clear = clr_at_hs;
    tick();
    i_ready = 1'b0;
    i_clear = 1'b0;
    i_valid = 1'b0;
    for (int d = 0; d < 4; d++) begin
      if (clr_at_hs) begin
        exp_acc[d] = 0;
        exp_sat[d] = 1'b0;
      end else if (acc) begin
        exp_acc[d] = exp_acc[d] + longint'(cnt_exp[d]);
        if (exp_acc[d] > acc_max[d]) begin
          exp_acc[d] = acc_max[d];
          exp_sat[d] = 1'b1;
        end
      end else begin
        exp_acc[d] = longint'(cnt_exp[d]);
      end
      check_eq($sformatf("acc[%0d]", d), oacc[d], exp_acc[d]);
      check_eq($sformatf("sat[%0d]", d), osat[d], exp_sat[d]);
      check_eq($sformatf("valid_after_hs[%0d]", d), ov[d], 0);
      check_eq($sformatf("count_after_hs[%0d]", d), ocnt[d], 0);
      check_eq($sformatf("ready_after_hs[%0d]", d), ordy[d], 1);
    end
  endtask

  task automatic pulse_clear();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    model_reset();
    for (int d = 0; d < 4; d++) begin
      check_eq($sformatf("clr_acc[%0d]", d), oacc[d], exp_acc[d]);
      check_eq($sformatf("clr_sat[%0d]", d), osat[d], exp_sat[d]);
    end
  endtask

  task automatic run_reset_mid();
    bit seen [4];
    i_data       = {$urandom, $urandom, $urandom, $urandom};
    i_accumulate = 1'b1;
    i_valid      = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 4; d++) begin
      check_eq($sformatf("rst_valid[%0d]", d), ov[d], 0);
      check_eq($sformatf("rst_count[%0d]", d), ocnt[d], 0);
      check_eq($sformatf("rst_acc[%0d]", d), oacc[d], exp_acc[d]);
      check_eq($sformatf("rst_sat[%0d]", d), osat[d], exp_sat[d]);
      check_eq($sformatf("rst_state[%0d]", d), ost[d], ST_IDLE);
      seen[d] = 1'b0;
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      for (int d = 0; d < 4; d++) if (ov[d]) seen[d] = 1'b1;
    end
    for (int d = 0; d < 4; d++) begin
      check_eq($sformatf("abandoned_valid[%0d]", d), seen[d], 0);
      check_eq($sformatf("post_rst_ready[%0d]", d), ordy[d], 1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] ones;
    logic [127:0] rnd;
    ones         = '1;
    rst_n        = 1'b0;
    i_valid      = 1'b0;
    i_accumulate = 1'b0;
    i_clear      = 1'b0;
    i_ready      = 1'b0;
    i_data       = '0;
    model_reset();
    repeat (3) tick();
    for (int d = 0; d < 4; d++) begin
      check_eq($sformatf("reset_valid[%0d]", d), ov[d], 0);
      check_eq($sformatf("reset_count[%0d]", d), ocnt[d], 0);
      check_eq($sformatf("reset_acc[%0d]", d), oacc[d], 0);
      check_eq($sformatf("reset_sat[%0d]", d), osat[d], 0);
      check_eq($sformatf("reset_state[%0d]", d), ost[d], ST_IDLE);
    end
    rst_n = 1'b1;
    tick();

    // All-ones load, all-zeros word, nibble pattern then accumulate a single bit.
    run_word(ones, 1'b0, 0, 1'b0, 1'b0);
    run_word('0, 1'b0, 1, 1'b0, 1'b0);
    run_word({16{8'h0F}}, 1'b0, 0, 1'b0, 1'b0);
    run_word(128'h1, 1'b1, 0, 1'b0, 1'b0);

    // Stalled output with a competing word offered throughout.
    run_word({$urandom, $urandom, $urandom, $urandom}, 1'b1, 5, 1'b1, 1'b0);
    run_word(128'hA5, 1'b1, 0, 1'b0, 1'b0);

    // Saturation of the narrow accumulator, then clear.
    pulse_clear();
    repeat (3) run_word(ones, 1'b1, 0, 1'b0, 1'b0);
    pulse_clear();

    // Clear coinciding with the output handshake, then reset mid-reduction.
    run_word(128'h1F, 1'b1, 0, 1'b0, 1'b0);
    run_word(128'h1F, 1'b1, 0, 1'b0, 1'b1);
    run_reset_mid();
    run_word(128'hF0F0_0000_0000_0000_0000_0000_0000_00FF, 1'b0, 0, 1'b0, 1'b0);

    // Randomized traffic with varied density, stalls and clears.
    for (int t = 0; t < 30; t++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 3))
        0: rnd = rnd & {$urandom, $urandom, $urandom, $urandom};
        1: rnd = rnd | {$urandom, $urandom, $urandom, $urandom};
        default: ;
      endcase
      run_word(rnd, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
